core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 16-bit core datapath. Owns the PC and the single
//  shared memory port, which it time-shares between instruction fetch and load/store. Drives the
//  datapath strobes en_s/en_c/en_reg and done. Instr: [15:13] Rx, [12:10] Ry, [4:2] sel, [1:0] fmt.
//  fmt 0 reg ALU, 1 imm ALU, 2 cond branch (imm [12:5]), 3 load(bit2=0)/store(bit2=1).
// PARAMETERS
//  RESET_PC     16'h0000  PC value after reset
//  MEM_TIMEOUT  255       max wait cycles for mem_ack before FAULT (1..65535)
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   synchronous, active-high
//  run        in   1   1 = start/continue executing; sampled in IDLE and DONE
//  branch_res in   1   datapath branch condition, sampled in EXEC for fmt 2
//  mem_req    out  1   memory access request, held until mem_ack
//  mem_we     out  1   1 = write (store), valid while mem_req
//  mem_addr   out  16  access address, stable while mem_req
//  mem_wdata  out  16  store data (= ls_wdata), valid while mem_req & mem_we
//  mem_ack    in   1   access complete; may assert in first cycle of mem_req
//  mem_rdata  in   16  read data, valid with mem_ack on reads
//  ls_addr    in   16  load/store address from datapath (registers[Ry])
//  ls_wdata   in   16  store data from datapath (registers[Rx])
//  instr      out  16  latched instruction register
//  ld_data    out  16  latched load data, feeds register write on loads
//  en_s       out  1   operand-latch strobe, 1-cycle pulse
//  en_c       out  1   ALU-result-latch strobe, 1-cycle pulse
//  en_reg     out  8   one-hot register write enable (bit Rx), 1-cycle pulse
//  pc         out  16  program counter
//  retired    out  16  instructions completed, wraps 16'hFFFF -> 0
//  done       out  1   1-cycle pulse per retired instruction
//  fault      out  1   sticky memory-timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instr=0, ld_data=0, retired=0, fault=0, all strobes/mem_req=0.
//  Reset asserted mid-instruction aborts it at that edge; no en_reg/done for the aborted instr.
//  States: IDLE -> FETCH -> DECODE -> SETUP -> EXEC -> {MEM} -> WRITE -> DONE; plus FAULT.
//  IDLE: run=1 -> FETCH, else stay.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: instr<=mem_rdata, pc<=pc+1 (wraps) -> DECODE.
//  DECODE: 1 cycle, no strobes. SETUP: en_s=1. EXEC: en_c=1.
//   fmt 2 in EXEC: branch_res=1 -> pc<=pc+sext(instr[12:5]) (mod 2^16); 0 -> pc unchanged.
//   EXEC -> MEM if fmt 3, else WRITE.
//  MEM: mem_req=1, mem_addr=ls_addr, mem_we=instr[2], mem_wdata=ls_wdata.
//   On mem_ack: loads latch ld_data<=mem_rdata -> WRITE.
//  WRITE: en_reg=1<<Rx for fmt 0, 1, and loads; en_reg=0 for fmt 2 and stores.
//  DONE: done=1, retired<=retired+1; run=1 -> FETCH, run=0 -> IDLE.
//  run=0 mid-instruction: current instruction completes; then IDLE.
//  Wait counter: cleared on entry to FETCH/MEM, increments each cycle without mem_ack. If it
//   reaches MEM_TIMEOUT: fault<=1, mem_req drops -> FAULT. FAULT is terminal until reset (no strobes).
//  Latency (zero-wait ack): ALU/branch 6 cycles, load/store 7 cycles from FETCH entry to done.
//  Never more than one of en_s, en_c, en_reg!=0, done, mem_req high in the same cycle.
// TESTING
//  1 Reset, run=1, mem[0]=16'h2401 (fmt1 Rx=1 imm=0x20), ack same cycle -> en_s,en_c,en_reg=8'h02
//    in consecutive states; done at cycle 6; pc=1, retired=1.
//  2 Load mem[1]=16'h4403 (Rx=2, bit2=0), ls_addr=16'h0010, mem[0x10]=16'hBEEF -> 2nd mem_req
//    addr 0x0010 we=0; ld_data=BEEF; en_reg=8'h04.
//  3 Store 16'h4407, ls_wdata=16'h1234 -> mem_we=1, mem_wdata=1234, en_reg stays 0, done pulses.
//  4 Branch instr[12:5]=8'hFE at pc=5: branch_res=1 -> next fetch addr 4; branch_res=0 -> addr 6.
//  5 mem_ack held low, MEM_TIMEOUT=4 -> fault=1 after 4 wait cycles, mem_req=0, no done until reset.
//  6 Reset pulsed during MEM; run=0 with retired=16'hFFFF at DONE -> next retire reads 0; IDLE
//    holds with no mem_req.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Shared memory port: the sequencer drives requests (master), memory answers (slave).
// One port carries both instruction fetches and load/store accesses.
interface core_sequencer_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic [15:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 16-bit core: owns PC, time-shares the memory
// port between fetch and load/store, and pulses the datapath strobes once per state.
module core_sequencer #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             branch_res,
   core_sequencer_if.master mem,
   input  logic [15:0]      ls_addr,
   input  logic [15:0]      ls_wdata,
   output logic [15:0]      instr,
   output logic [15:0]      ld_data,
   output logic             en_s,
   output logic             en_c,
   output logic [7:0]       en_reg,
   output logic [15:0]      pc,
   output logic [15:0]      retired,
   output logic             done,
   output logic             fault
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_SETUP  = 4'd3,
      ST_EXEC   = 4'd4,
      ST_MEM    = 4'd5,
      ST_WRITE  = 4'd6,
      ST_DONE   = 4'd7,
      ST_FAULT  = 4'd8
   } state_t;

   // Last wait count that is still tolerated; one more cycle without ack is a fault.
   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 32'd1);

   state_t      state_r, state_s;
   logic [15:0] pc_r, pc_s;
   logic [15:0] instr_r, instr_s;
   logic [15:0] ld_data_r, ld_data_s;
   logic [15:0] retired_r, retired_s;
   logic [15:0] wait_r, wait_s;
   logic        fault_r, fault_s;
   logic        req_r, we_r, en_s_r, en_c_r, done_r;
   logic [7:0]  en_reg_r;

   // Register write-back happens for ALU formats and loads only.
   function automatic logic writes_rx(input logic [15:0] ir);
      case (ir[1:0])
         2'd0, 2'd1: writes_rx = 1'b1;
         2'd3:       writes_rx = ~ir[2];
         default:    writes_rx = 1'b0;
      endcase
   endfunction

   // Next-state and architectural-register update logic.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      instr_s   = instr_r;
      ld_data_s = ld_data_r;
      retired_s = retired_r;
      wait_s    = wait_r;
      fault_s   = fault_r;
      case (state_r)
         ST_IDLE: begin
            if (run) begin
               state_s = ST_FETCH;
               wait_s  = 16'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (mem.ack) begin
               instr_s = mem.rdata;
               pc_s    = pc_r + 16'd1;
               state_s = ST_DECODE;
            end else if (wait_r == WAIT_LAST) begin
               fault_s = 1'b1;
               state_s = ST_FAULT;
            end else begin
               wait_s = wait_r + 16'd1;
            end
         end
         ST_DECODE: state_s = ST_SETUP;
         ST_SETUP:  state_s = ST_EXEC;
         ST_EXEC: begin
            if ((instr_r[1:0] == 2'd2) && branch_res) begin
               pc_s = pc_r + {{8{instr_r[12]}}, instr_r[12:5]};
            end else begin
               pc_s = pc_r;
            end
            if (instr_r[1:0] == 2'd3) begin
               state_s = ST_MEM;
               wait_s  = 16'd0;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_MEM: begin
            if (mem.ack) begin
               if (!instr_r[2]) begin
                  ld_data_s = mem.rdata;
               end else begin
                  ld_data_s = ld_data_r;
               end
               state_s = ST_WRITE;
            end else if (wait_r == WAIT_LAST) begin
               fault_s = 1'b1;
               state_s = ST_FAULT;
            end else begin
               wait_s = wait_r + 16'd1;
            end
         end
         ST_WRITE: state_s = ST_DONE;
         ST_DONE: begin
            retired_s = retired_r + 16'd1;
            if (run) begin
               state_s = ST_FETCH;
               wait_s  = 16'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FAULT: state_s = ST_FAULT;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State, datapath registers and strobes; strobes decode the upcoming state so they are flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pc_r      <= RESET_PC;
         instr_r   <= 16'h0000;
         ld_data_r <= 16'h0000;
         retired_r <= 16'h0000;
         wait_r    <= 16'h0000;
         fault_r   <= 1'b0;
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         en_s_r    <= 1'b0;
         en_c_r    <= 1'b0;
         en_reg_r  <= 8'h00;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         instr_r   <= instr_s;
         ld_data_r <= ld_data_s;
         retired_r <= retired_s;
         wait_r    <= wait_s;
         fault_r   <= fault_s;
         req_r     <= (state_s == ST_FETCH) || (state_s == ST_MEM);
         we_r      <= (state_s == ST_MEM) && instr_s[2];
         en_s_r    <= (state_s == ST_SETUP);
         en_c_r    <= (state_s == ST_EXEC);
         en_reg_r  <= ((state_s == ST_WRITE) && writes_rx(instr_s)) ?
                      (8'd1 << instr_s[15:13]) : 8'h00;
         done_r    <= (state_s == ST_DONE);
      end
   end

   // Address follows the datapath during MEM so the load/store target is never stale.
   assign mem.req   = req_r;
   assign mem.we    = we_r;
   assign mem.addr  = (state_r == ST_MEM) ? ls_addr : pc_r;
   assign mem.wdata = ls_wdata;

   assign instr   = instr_r;
   assign ld_data = ld_data_r;
   assign en_s    = en_s_r;
   assign en_c    = en_c_r;
   assign en_reg  = en_reg_r;
   assign pc      = pc_r;
   assign retired = retired_r;
   assign done    = done_r;
   assign fault   = fault_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of instructions plus corner sequences, with a
// scoreboard of expected bus/strobe events checked by a negedge monitor.
module tb_core_sequencer;

   localparam logic [2:0] EV_ACC  = 3'd0;
   localparam logic [2:0] EV_S    = 3'd1;
   localparam logic [2:0] EV_C    = 3'd2;
   localparam logic [2:0] EV_REG  = 3'd3;
   localparam logic [2:0] EV_DONE = 3'd4;

   typedef struct {
      logic [2:0]  kind;
      logic [15:0] addr;
      logic        we;
      logic [15:0] data;
   } ev_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] ls_addr;
      logic [15:0] ls_wdata;
      logic [15:0] ld_val;
      logic        br;
      logic [1:0]  memk;
      logic [7:0]  exp_en_reg;
      logic [15:0] exp_pc;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, run, branch_res, ack_en;
   logic [15:0] ls_addr, ls_wdata;
   logic [15:0] instr, ld_data, pc, retired;
   logic        en_s, en_c, done, fault;
   logic [7:0]  en_reg;
   logic [15:0] mem [0:65535];

   int  compared;
   int  mismatched;
   int  mon_act;
   ev_t exp_q [$];

   core_sequencer_if bus ();

   core_sequencer #(.RESET_PC(16'h0000), .MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .branch_res (branch_res),
      .mem        (bus),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .instr      (instr),
      .ld_data    (ld_data),
      .en_s       (en_s),
      .en_c       (en_c),
      .en_reg     (en_reg),
      .pc         (pc),
      .retired    (retired),
      .done       (done),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   assign bus.ack   = bus.req & ack_en;
   assign bus.rdata = mem[bus.addr];

   function automatic ev_t mk_ev(input logic [2:0] k, input logic [15:0] a, input logic w,
                                 input logic [15:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.we = w; e.data = d;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic [15:0] ir, input logic [15:0] la,
                                   input logic [15:0] wd, input logic [15:0] lv, input logic br,
                                   input logic [1:0] mk, input logic [7:0] er,
                                   input logic [15:0] npc, input int lat);
      vec_t v;
      v.instr = ir; v.ls_addr = la; v.ls_wdata = wd; v.ld_val = lv; v.br = br;
      v.memk = mk; v.exp_en_reg = er; v.exp_pc = npc; v.exp_lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic observe(input ev_t got);
      ev_t e;
      logic bad;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL sb_unexpected: got kind %0d addr %h we %0b data %h, expected no event",
                  got.kind, got.addr, got.we, got.data);
      end else begin
         e   = exp_q.pop_front();
         bad = (got.kind != e.kind);
         if ((e.kind == EV_ACC || e.kind == EV_DONE) && got.addr != e.addr) bad = 1'b1;
         if (e.kind == EV_ACC && got.we != e.we) bad = 1'b1;
         if (((e.kind == EV_ACC && e.we) || e.kind == EV_REG) && got.data != e.data) bad = 1'b1;
         if (bad) begin
            mismatched++;
            $display("FAIL sb_event: got kind %0d addr %h we %0b data %h, expected kind %0d addr %h we %0b data %h",
                     got.kind, got.addr, got.we, got.data, e.kind, e.addr, e.we, e.data);
         end
      end
   endtask

   task automatic push_instr(input logic [15:0] fpc, input logic [1:0] memk,
                             input logic [15:0] la, input logic [15:0] wd,
                             input logic [7:0] er, input logic [15:0] npc);
      exp_q.push_back(mk_ev(EV_ACC, fpc, 1'b0, 16'h0000));
      exp_q.push_back(mk_ev(EV_S, 16'h0000, 1'b0, 16'h0000));
      exp_q.push_back(mk_ev(EV_C, 16'h0000, 1'b0, 16'h0000));
      if (memk != 2'd0) exp_q.push_back(mk_ev(EV_ACC, la, (memk == 2'd2), wd));
      if (er != 8'h00) exp_q.push_back(mk_ev(EV_REG, 16'h0000, 1'b0, {8'h00, er}));
      exp_q.push_back(mk_ev(EV_DONE, npc, 1'b0, 16'h0000));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   // Monitor: strobe exclusivity and scoreboard events, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         mon_act = int'(en_s) + int'(en_c) + int'(en_reg != 8'h00) + int'(done) + int'(bus.req);
         check("exclusive", mon_act, (mon_act > 1) ? 32'd1 : mon_act);
         if (bus.req && bus.ack) observe(mk_ev(EV_ACC, bus.addr, bus.we, bus.wdata));
         if (en_s) observe(mk_ev(EV_S, 16'h0000, 1'b0, 16'h0000));
         if (en_c) observe(mk_ev(EV_C, 16'h0000, 1'b0, 16'h0000));
         if (en_reg != 8'h00) observe(mk_ev(EV_REG, 16'h0000, 1'b0, {8'h00, en_reg}));
         if (done) observe(mk_ev(EV_DONE, pc, 1'b0, 16'h0000));
      end
   end

   initial begin
      int   n;
      int   bad;
      vec_t v [10];
      logic [15:0] cur_pc;

      compared = 0; mismatched = 0;
      reset = 1'b1; run = 1'b0; branch_res = 1'b0; ack_en = 1'b1;
      ls_addr = 16'h0000; ls_wdata = 16'h0000;
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

      v[0] = mk_vec(16'h2401, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 8'h02, 16'h0001, 6);
      v[1] = mk_vec(16'h4403, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2'd1, 8'h04, 16'h0002, 7);
      v[2] = mk_vec(16'h4407, 16'h0020, 16'h1234, 16'h0000, 1'b0, 2'd2, 8'h00, 16'h0003, 7);
      v[3] = mk_vec(16'hE000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 8'h80, 16'h0004, 6);
      v[4] = mk_vec(16'h6000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 8'h08, 16'h0005, 6);
      v[5] = mk_vec(16'h1FC2, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 8'h00, 16'h0004, 6);
      v[6] = mk_vec(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 8'h01, 16'h0005, 6);
      v[7] = mk_vec(16'h1FC2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 8'h00, 16'h0006, 6);
      v[8] = mk_vec(16'h0202, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 8'h00, 16'h0017, 6);
      v[9] = mk_vec(16'hA003, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 2'd1, 8'h20, 16'h0018, 7);

      repeat (3) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_ld_data", ld_data, 32'h0);
      check("rst_retired", retired, 32'h0);
      check("rst_fault", fault, 32'h0);
      check("rst_req", bus.req, 32'h0);
      check("rst_en_reg", en_reg, 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_req", bus.req, 32'h0);

      cur_pc = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         mem[cur_pc] = v[i].instr;
         ls_addr     = v[i].ls_addr;
         ls_wdata    = v[i].ls_wdata;
         branch_res  = v[i].br;
         if (v[i].memk == 2'd1) mem[v[i].ls_addr] = v[i].ld_val;
         push_instr(cur_pc, v[i].memk, v[i].ls_addr, v[i].ls_wdata, v[i].exp_en_reg, v[i].exp_pc);
         run = 1'b1;
         wait_done(n);
         check("latency", n, v[i].exp_lat);
         check("pc_at_done", pc, {16'h0000, v[i].exp_pc});
         check("retired_at_done", retired, i);
         if (v[i].memk == 2'd1) check("ld_data", ld_data, {16'h0000, v[i].ld_val});
         cur_pc = v[i].exp_pc;
      end
      run = 1'b0;
      @(negedge clk);
      check("retired_after_table", retired, 32'd10);
      check("idle_after_table", bus.req, 32'h0);

      // Wait states up to the last tolerated count, with run dropped mid-instruction.
      mem[16'h0018] = 16'h2401;
      push_instr(16'h0018, 2'd0, 16'h0000, 16'h0000, 8'h02, 16'h0019);
      ack_en = 1'b0; run = 1'b1; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) run = 1'b0;
         if (n == 4) begin
            check("wait_req_held", bus.req, 32'h1);
            check("wait_addr", bus.addr, 32'h0018);
            check("wait_no_fault", fault, 32'h0);
            ack_en = 1'b1;
         end
      end while (!done && n < 40);
      check("wait_latency", n, 32'd9);
      check("wait_fault", fault, 32'h0);
      @(negedge clk);
      check("run0_idle", bus.req, 32'h0);
      check("run0_retired", retired, 32'd11);

      // Retired counter wrap from 16'hFFFF.
      force dut.retired_r = 16'hFFFF;
      @(negedge clk);
      release dut.retired_r;
      @(negedge clk);
      check("wrap_pre", retired, 32'hFFFF);
      mem[16'h0019] = 16'h0001;
      push_instr(16'h0019, 2'd0, 16'h0000, 16'h0000, 8'h01, 16'h001A);
      run = 1'b1;
      wait_done(n);
      run = 1'b0;
      check("wrap_latency", n, 32'd6);
      @(negedge clk);
      check("wrap_retired", retired, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("wrap_idle", bus.req, 32'h0);
      end

      // Reset while the load is stalled in MEM aborts it.
      mem[16'h001A] = 16'h4403;
      mem[16'h0030] = 16'h5555;
      ls_addr = 16'h0030;
      exp_q.push_back(mk_ev(EV_ACC, 16'h001A, 1'b0, 16'h0000));
      exp_q.push_back(mk_ev(EV_S, 16'h0000, 1'b0, 16'h0000));
      exp_q.push_back(mk_ev(EV_C, 16'h0000, 1'b0, 16'h0000));
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      ack_en = 1'b0;
      repeat (3) @(negedge clk);
      check("mem_req", bus.req, 32'h1);
      check("mem_addr", bus.addr, 32'h0030);
      check("mem_we", bus.we, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_req", bus.req, 32'h0);
      check("abort_pc", pc, 32'h0);
      check("abort_instr", instr, 32'h0);
      check("abort_ld_data", ld_data, 32'h0);
      check("abort_retired", retired, 32'h0);
      reset = 1'b0; ack_en = 1'b1;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || en_reg != 8'h00 || bus.req) bad++;
      end
      check("abort_quiet", bad, 32'd0);
      check("abort_sb_empty", exp_q.size(), 32'd0);

      // Memory timeout: no ack for MEM_TIMEOUT cycles, then terminal FAULT.
      ack_en = 1'b0; run = 1'b1;
      repeat (4) @(negedge clk);
      check("to_req_last", bus.req, 32'h1);
      check("to_fault_early", fault, 32'h0);
      @(negedge clk);
      check("to_fault", fault, 32'h1);
      check("to_req_drop", bus.req, 32'h0);
      ack_en = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || bus.req || en_s || en_c) bad++;
      end
      check("fault_terminal", bad, 32'd0);
      check("fault_sticky", fault, 32'h1);
      run = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("fault_cleared", fault, 32'h0);
      @(negedge clk);
      check("post_reset_idle", bus.req, 32'h0);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
